// File: rtl/debug_lock_pkg.sv
// rtl/debug_lock_pkg.sv - shared state encoding and defaults for the debug unlock arbiter
package debug_lock_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_CHECK    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } lock_state_e;

  localparam logic [5:0] DEF_KEY            = 6'h2A;
  localparam int         DEF_MAX_FAIL       = 3;
  localparam int         DEF_LOCKOUT_CYCLES = 16;
  localparam int         DEF_IDLE_TIMEOUT   = 64;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter, pointer advances past each grant
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  // Granting requester 0 hands priority to 1, and vice versa.
  always_ff @(posedge clk) begin
    if (reset)       ptr <= 1'b0;
    else if (accept) ptr <= grant[0];
  end

endmodule

// File: rtl/debug_unlock_arbiter.sv
// rtl/debug_unlock_arbiter.sv - key-gated debug register with lockout, idle relock and RR write arbitration
module debug_unlock_arbiter
  import debug_lock_pkg::*;
#(
  parameter logic [5:0] KEY            = DEF_KEY,
  parameter int         MAX_FAIL       = DEF_MAX_FAIL,
  parameter int         LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int         IDLE_TIMEOUT   = DEF_IDLE_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       unlock_valid,
  input  logic [5:0] unlock_key,
  output logic       unlock_ready,
  input  logic       req0_valid,
  input  logic [5:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [5:0] req1_data,
  output logic       req1_ready,
  input  logic       relock,
  output logic [5:0] data,
  output logic       locked,
  output logic       lockout,
  output logic [1:0] fail_cnt
);

  localparam int         TW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int         IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [1:0] MF = 2'(MAX_FAIL);

  lock_state_e   state, state_nxt;
  logic [5:0]    key_q;
  logic [TW-1:0] lock_tmr;
  logic [IW-1:0] idle_cnt;
  logic          wr_en, wr_acc, key_match, idle_done;
  logic [1:0]    grant;

  // relock blocks any write in the same cycle it is seen
  assign wr_en     = (state == ST_UNLOCKED) && !relock;
  assign key_match = (key_q == KEY);
  assign idle_done = (idle_cnt == IW'(IDLE_TIMEOUT - 1));

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid  ({req1_valid, req0_valid} & {2{wr_en}}),
    .accept (wr_acc),
    .grant  (grant)
  );

  assign wr_acc     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign locked     = (state != ST_UNLOCKED);
  assign lockout    = (state == ST_LOCKOUT);

  always_comb begin
    state_nxt    = state;
    unlock_ready = 1'b0;
    case (state)
      ST_LOCKED: begin
        unlock_ready = 1'b1;
        if (unlock_valid) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (key_match)                     state_nxt = ST_UNLOCKED;
        else if (sat_inc2(fail_cnt) == MF) state_nxt = ST_LOCKOUT;
        else                               state_nxt = ST_LOCKED;
      end
      ST_UNLOCKED: begin
        // a write landing on the timeout cycle restarts the idle window
        if (relock || (idle_done && !wr_acc)) state_nxt = ST_LOCKED;
      end
      ST_LOCKOUT: begin
        if (lock_tmr == '0) state_nxt = ST_LOCKED;
      end
      default: state_nxt = ST_LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_LOCKED;
      key_q    <= 6'h00;
      fail_cnt <= 2'd0;
      lock_tmr <= '0;
      idle_cnt <= '0;
      data     <= 6'h00;
    end else begin
      state <= state_nxt;
      if (state == ST_LOCKED && unlock_valid) key_q <= unlock_key;

      if (state == ST_CHECK)
        fail_cnt <= key_match ? 2'd0 : sat_inc2(fail_cnt);
      else if (state == ST_LOCKOUT && lock_tmr == '0)
        fail_cnt <= 2'd0;

      if (state != ST_LOCKOUT && state_nxt == ST_LOCKOUT)
        lock_tmr <= TW'(LOCKOUT_CYCLES - 1);
      else if (state == ST_LOCKOUT && lock_tmr != '0)
        lock_tmr <= lock_tmr - 1'b1;

      if (state != ST_UNLOCKED || wr_acc) idle_cnt <= '0;
      else                                idle_cnt <= idle_cnt + 1'b1;

      if (wr_acc) data <= grant[1] ? req1_data : req0_data;
    end
  end

endmodule

// File: doc/debug_unlock_arbiter.md
DEBUG_UNLOCK_ARBITER -- requirements
Module: debug_unlock_arbiter

Interface
REQ-001 SHALL provide parameter KEY, default 6'h2A, unlock key compared against unlock_key.
REQ-002 SHALL provide parameter MAX_FAIL, default 3, failed attempts that trigger lockout (range 1-3).
REQ-003 SHALL provide parameter LOCKOUT_CYCLES, default 16, lockout duration in clk cycles (>=1).
REQ-004 SHALL provide parameter IDLE_TIMEOUT, default 64, idle cycles in UNLOCKED before automatic relock (>=1).
REQ-005 clk  in  1  clock; all logic on posedge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 unlock_valid  in  1  unlock attempt offered.
REQ-008 unlock_key  in  6  key presented with unlock_valid.
REQ-009 unlock_ready  out  1  attempt accepted when unlock_valid && unlock_ready.
REQ-010 req0_valid / req0_data / req0_ready  in / in / out  1 / 6 / 1  requester 0 (JTAG) write channel.
REQ-011 req1_valid / req1_data / req1_ready  in / in / out  1 / 6 / 1  requester 1 (CPU) write channel.
REQ-012 relock  in  1  force return to LOCKED.
REQ-013 data  out  6  protected register contents.
REQ-014 locked  out  1  high in every state except UNLOCKED.
REQ-015 lockout  out  1  high only in LOCKOUT.
REQ-016 fail_cnt  out  2  consecutive failed attempts.

Function
REQ-017 SHALL implement FSM states LOCKED, CHECK, UNLOCKED, LOCKOUT.
REQ-018 LOCKED: unlock_ready=1; on accepted attempt capture unlock_key, go CHECK next cycle.
REQ-019 CHECK (exactly one cycle, unlock_ready=0): match -> UNLOCKED, fail_cnt<=0; mismatch -> fail_cnt+1, then LOCKOUT if new count == MAX_FAIL, else LOCKED.
REQ-020 Entering LOCKOUT SHALL load timer with LOCKOUT_CYCLES-1; decrement each cycle; at 0 -> LOCKED with fail_cnt<=0; unlock_ready=0 throughout.
REQ-021 Write channels: reqN_ready SHALL be 0 outside UNLOCKED; data SHALL never change outside UNLOCKED.
REQ-022 UNLOCKED: at most one write accepted per cycle; single valid requester granted immediately; both valid -> round-robin pointer decides, pointer moves to the other requester after each grant; pointer resets to requester 0.
REQ-023 Accepted write SHALL appear on data the following cycle (latency 1).
REQ-024 Idle counter SHALL clear on entry to UNLOCKED and on every accepted write, otherwise increment; reaching IDLE_TIMEOUT-1 -> LOCKED next cycle.
REQ-025 relock in UNLOCKED SHALL force LOCKED next cycle, deassert both ready combinationally that cycle (no write accepted); relock ignored in other states.
REQ-026 unlock_valid in UNLOCKED SHALL be ignored (unlock_ready=0).
REQ-027 fail_cnt SHALL saturate, never wrap.

Reset
REQ-028 reset SHALL force state LOCKED, data 6'h00, fail_cnt 0, timers 0, RR pointer 0, all ready outputs per LOCKED (unlock_ready=1, reqN_ready=0), overriding any in-flight handshake, including mid-CHECK and mid-LOCKOUT.

Structure
REQ-029 State enum and default parameter constants SHALL live in shared package debug_lock_pkg.
REQ-030 Two-requester round-robin arbitration SHALL be sub-module rr_arb2 (valid[1:0] in, grant[1:0] out, pointer update on accept).

Verification
REQ-031 Reset, then unlock_key 6'h2A -> CHECK 1 cycle, UNLOCKED, locked=0, fail_cnt=0.
REQ-032 Three attempts with 6'h00 -> fail_cnt 1,2 then LOCKOUT; lockout=1, unlock_ready=0 for 16 cycles, then LOCKED, fail_cnt=0.
REQ-033 UNLOCKED, req0=6'h11 and req1=6'h22 valid together for 2 cycles -> data 6'h11 then 6'h22, one ready high per cycle.
REQ-034 UNLOCKED, no writes for 64 cycles -> locked=1; subsequent req0_valid gets ready=0, data unchanged.
REQ-035 relock asserted with req0_valid same cycle -> req0_ready=0, data unchanged, LOCKED next cycle.
REQ-036 reset asserted during LOCKOUT -> next cycle LOCKED, lockout=0, fail_cnt=0, data=6'h00.
